// File: rtl/mem_dcache.sv
// mem_dcache: direct-mapped, write-back, write-allocate data cache between the MEM stage and main memory.
// Define DCACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module mem_dcache #(
    parameter int unsigned INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 14 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [63:0]           data_q [LINES];
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [63:0]           line;
    logic                  access;
    logic                  hit;
    logic                  store_hit;
    logic                  wb_done;
    logic                  fill_done;

    assign offset    = addr[1:0];
    assign index     = addr[INDEX_BITS+1:2];
    assign tag       = addr[15:INDEX_BITS+2];
    assign line      = data_q[index];
    assign access    = re | we;
    assign hit       = (state_q == IDLE) && valid_q[index] && (tag_q[index] == tag);
    assign store_hit = hit & we;
    assign wb_done   = (state_q == WB) & mem_rdy;
    assign fill_done = (state_q == FILL) & mem_rdy;

    // Load data is only meaningful on an IDLE hit; drive zero otherwise.
    assign rdata = hit ? line[{offset, 4'b0000} +: 16] : 16'h0000;
    assign stall = (state_q != IDLE) | (access & ~hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access && !hit) begin
                    state_d = (valid_q[index] && dirty_q[index]) ? WB : FILL;
                end
            end
            WB: begin
                if (mem_rdy) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory request is registered from the next state, so it is up in the first WB/FILL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 64'h0;
        end else begin
            mem_req <= (state_d != IDLE);
            case (state_d)
                WB: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= {tag_q[index], index, 2'b00};
                    mem_wdata <= line;
                end
                FILL: begin
                    mem_we   <= 1'b0;
                    mem_addr <= {tag, index, 2'b00};
                end
                default: mem_we <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (wb_done) begin
            dirty_q[index] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Data and tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[index] <= mem_rdata;
            tag_q[index]  <= tag;
        end else if (store_hit) begin
            data_q[index][{offset, 4'b0000} +: 16] <= wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic just_filled_q;

    // The completing hit right after a refill belongs to the miss, not to the hit count.
    always_ff @(posedge clk) begin
        if (rst) begin
            just_filled_q <= 1'b0;
            hit_cnt       <= 16'h0000;
            miss_cnt      <= 16'h0000;
        end else begin
            just_filled_q <= fill_done;
            if (access && hit && !just_filled_q && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'h0001;
            end
            if ((state_q == IDLE) && (state_d != IDLE) && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_dcache.sv
// tb_mem_dcache: randomized self-checking bench for mem_dcache against a flat-memory reference model.
// Stats checks are compiled in when DCACHE_STATS_EN is defined.
module tb_mem_dcache;

    localparam int unsigned IB = 4;
    localparam int unsigned TW = 14 - IB;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    mem_dcache #(.INDEX_BITS(IB)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .re       (re),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdy  (mem_rdy)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: golden = what a load must return, backing = what main memory holds.
    logic [15:0] golden  [65536];
    logic [15:0] backing [65536];
    bit          mv [1 << IB];
    bit          md [1 << IB];
    logic [TW-1:0] mt [1 << IB];

    function automatic logic [63:0] line_of(input logic [15:0] a);
        logic [15:0] b;
        b = {a[15:2], 2'b00};
        return {golden[b + 16'd3], golden[b + 16'd2], golden[b + 16'd1], golden[b]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < (1 << IB); i++) begin
            if (mv[i] && md[i]) begin
                for (int k = 0; k < 4; k++) begin
                    golden[{mt[i], IB'(i), 2'(k)}] = backing[{mt[i], IB'(i), 2'(k)}];
                end
            end
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; re = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One CPU access; acts as main memory with the given write-back / fill latencies.
    task automatic access(input logic [15:0] a, input logic r, input logic w,
                          input logic [15:0] d, input int lw, input int lf);
        int idx;
        logic [TW-1:0] tg;
        bit hit_e, dirty_e, exp_wb, done;
        int exp_stall, cyc, ph;
        logic [15:0] va, fa;
        logic [63:0] vline;
        idx     = int'(a[IB+1:2]);
        tg      = a[15:IB+2];
        hit_e   = mv[idx] && (mt[idx] == tg);
        dirty_e = !hit_e && mv[idx] && md[idx];
        va      = {mt[idx], a[IB+1:2], 2'b00};
        fa      = {a[15:2], 2'b00};
        vline   = line_of(va);
        exp_stall = hit_e ? 0 : 1 + (dirty_e ? lw : 0) + lf;
        exp_wb  = dirty_e;
        addr = a; re = r; we = w; wdata = d;
        cyc = 0; ph = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                checks++;
                if (cyc != exp_stall) begin
                    errors++;
                    $display("FAIL stall_cycles addr=%h: got %0d expected %0d", a, cyc, exp_stall);
                end
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL mem_req_on_hit addr=%h: got %b expected 0", a, mem_req);
                end
                if (r && !w) begin
                    checks++;
                    if (rdata !== golden[a]) begin
                        errors++;
                        $display("FAIL rdata addr=%h: got %h expected %h", a, rdata, golden[a]);
                    end
                end
            end else if (cyc >= 60) begin
                errors++;
                $display("FAIL timeout addr=%h: stall still %b after %0d cycles", a, stall, cyc);
                done = 1'b1;
            end else begin
                if (cyc == 0) begin
                    checks++;
                    if (rdata !== 16'h0000) begin
                        errors++;
                        $display("FAIL rdata_on_miss addr=%h: got %h expected 0000", a, rdata);
                    end
                end
                cyc++;
                if (mem_req === 1'b1) begin
                    ph++;
                    if (ph == 1) begin
                        checks++;
                        if (mem_we !== exp_wb || mem_addr !== (exp_wb ? va : fa)) begin
                            errors++;
                            $display("FAIL mem_cmd addr=%h: got we=%b maddr=%h expected we=%b maddr=%h",
                                     a, mem_we, mem_addr, exp_wb, exp_wb ? va : fa);
                        end
                        if (exp_wb) begin
                            checks++;
                            if (mem_wdata !== vline) begin
                                errors++;
                                $display("FAIL wb_data addr=%h: got %h expected %h", a, mem_wdata, vline);
                            end
                        end
                    end
                    if (ph == (exp_wb ? lw : lf)) begin
                        mem_rdy   = 1'b1;
                        mem_rdata = exp_wb ? 64'h0 : line_of(fa);
                        ph        = 0;
                        exp_wb    = 1'b0;
                    end
                end
            end
            @(posedge clk); #1;
            mem_rdy = 1'b0;
        end
        re = 1'b0; we = 1'b0;
        if (dirty_e) begin
            for (int k = 0; k < 4; k++) backing[va + 16'(k)] = golden[va + 16'(k)];
        end
        if (!hit_e) begin
            mv[idx] = 1'b1; mt[idx] = tg; md[idx] = 1'b0;
        end
        if (w) begin
            md[idx] = 1'b1; golden[a] = d;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; re = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 16'h0000 || mem_wdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b req=%b we=%b maddr=%h mwd=%h expected all 0",
                     stall, mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fill();
        addr = 16'h0055; re = 1'b1; we = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0054) begin
            errors++;
            $display("FAIL fill_start: got req=%b we=%b maddr=%h expected 1 0 0054", mem_req, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; re = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_fill: got req=%b stall=%b expected 0 0", mem_req, stall);
        end
        mem_rdy = 1'b1; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL stray_rdy: got req=%b stall=%b expected 0 0", mem_req, stall);
        end
        @(posedge clk); #1;
        model_reset();
        access(16'h0055, 1'b1, 1'b0, 16'h0, 2, 2);
    endtask

    task automatic test_plan_directed();
        access(16'h0013, 1'b1, 1'b0, 16'h0, 3, 3);
        access(16'h0011, 1'b1, 1'b0, 16'h0, 1, 1);
        access(16'h0012, 1'b0, 1'b1, 16'hBEEF, 1, 1);
        checks++;
        if (line_of(16'h0010) !== 64'h0004_BEEF_0002_0001) begin
            errors++;
            $display("FAIL model_line: got %h expected 0004beef00020001", line_of(16'h0010));
        end
        access(16'h0412, 1'b1, 1'b0, 16'h0, 3, 2);
        access(16'h0013, 1'b1, 1'b0, 16'h0, 2, 2);
    endtask

    task automatic test_read_write_together();
        access(16'h0020, 1'b1, 1'b1, 16'h1234, 2, 2);
        access(16'h0020, 1'b1, 1'b0, 16'h0, 1, 1);
        access(16'h0420, 1'b1, 1'b0, 16'h0, 2, 3);
        access(16'h0020, 1'b1, 1'b0, 16'h0, 1, 2);
    endtask

    task automatic test_index_wrap();
        access(16'hFFFF, 1'b1, 1'b0, 16'h0, 1, 2);
        access(16'hFFFF, 1'b0, 1'b1, 16'hA5A5, 1, 1);
        access(16'h003F, 1'b1, 1'b0, 16'h0, 4, 1);
        access(16'hFFFF, 1'b1, 1'b0, 16'h0, 1, 3);
        access(16'h0000, 1'b0, 1'b1, 16'h5A5A, 1, 1);
        access(16'hFC00, 1'b1, 1'b0, 16'h0, 3, 4);
        access(16'h0000, 1'b1, 1'b0, 16'h0, 2, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            access(16'h0020 + 16'($urandom_range(0, 3)), 1'(i % 2), 1'((i + 1) % 2),
                   16'($urandom), 1, 1);
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        int op;
        for (int i = 0; i < 250; i++) begin
            a = (16'($urandom_range(0, 3)) << 6) | 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 16'hFC00;
            op = int'($urandom_range(0, 3));
            access(a, op != 2, op >= 2, 16'($urandom),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        do_reset();
        access(16'h0100, 1'b1, 1'b0, 16'h0, 2, 2);
        access(16'h0101, 1'b1, 1'b0, 16'h0, 1, 1);
        access(16'h0102, 1'b0, 1'b1, 16'h7777, 1, 1);
        access(16'h0103, 1'b1, 1'b0, 16'h0, 1, 1);
        @(negedge clk);
        checks++;
        if (miss_cnt !== 16'd1 || hit_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stats_count: got miss=%0d hit=%0d expected 1 3", miss_cnt, hit_cnt);
        end
        @(posedge clk); #1;
        addr = 16'h0101; re = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk); #1;
        end
        re = 1'b0;
        @(negedge clk);
        checks++;
        if (hit_cnt !== 16'hFFFF || miss_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stats_saturate: got hit=%h miss=%h expected ffff 0001", hit_cnt, miss_cnt);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1; addr = 16'h0; re = 1'b0; we = 1'b0; wdata = 16'h0;
        mem_rdata = 64'h0; mem_rdy = 1'b0;
        for (int i = 0; i < 65536; i++) golden[i] = 16'($urandom);
        golden[16'h0010] = 16'h0001;
        golden[16'h0011] = 16'h0002;
        golden[16'h0012] = 16'h0003;
        golden[16'h0013] = 16'h0004;
        for (int i = 0; i < 65536; i++) backing[i] = golden[i];
        for (int i = 0; i < (1 << IB); i++) begin
            mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0;
        end
        test_reset();
        test_reset_mid_fill();
        do_reset();
        test_plan_directed();
        test_read_write_together();
        test_index_wrap();
        test_back_to_back();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
